// File: rtl/truth_table_extractor.sv
// Sweeps all eight input rows of an attached 3-input logic block and assembles its truth-table code.
// The DUT output is synchronized and majority-voted per row.
module truth_table_extractor #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned SAMPLES       = 3,
    parameter int unsigned CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] expected,
    input  logic       dut_out,
    output logic       drv_in1,
    output logic       drv_in2,
    output logic       drv_in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] code,
    output logic       match,
    output logic [7:0] mismatch_mask
);

    localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SampLast   = CNT_W'(SAMPLES - 1);
    localparam logic [CNT_W-1:0] Half       = CNT_W'(SAMPLES / 2);

    typedef enum logic [1:0] {StIdle, StDrive, StSample, StDone} state_e;

    state_e           state_q;
    logic             sync1_q, sync2_q;
    logic [2:0]       row_q;
    logic [CNT_W-1:0] settle_q, samp_q, ones_q;
    logic [7:0]       shadow_q, exp_q;

    logic [CNT_W-1:0] ones_sum;
    logic             vote;
    logic [7:0]       shadow_upd;

    // Vote includes the sample taken on the exiting edge.
    always_comb begin
        ones_sum   = ones_q + CNT_W'(sync2_q);
        vote       = (ones_sum > Half);
        shadow_upd = shadow_q;
        shadow_upd[3'd7 - row_q] = vote;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            row_q         <= 3'd0;
            settle_q      <= '0;
            samp_q        <= '0;
            ones_q        <= '0;
            shadow_q      <= 8'h00;
            exp_q         <= 8'h00;
            drv_in1       <= 1'b0;
            drv_in2       <= 1'b0;
            drv_in3       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            code          <= 8'h00;
            match         <= 1'b0;
            mismatch_mask <= 8'h00;
        end else begin
            sync1_q <= dut_out;
            sync2_q <= sync1_q;
            done    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        exp_q    <= expected;
                        shadow_q <= 8'h00;
                        row_q    <= 3'd0;
                        settle_q <= SettleLoad;
                        {drv_in1, drv_in2, drv_in3} <= 3'b000;
                        busy     <= 1'b1;
                        state_q  <= StDrive;
                    end
                end
                StDrive: begin
                    if (abort) begin
                        {drv_in1, drv_in2, drv_in3} <= 3'b000;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else if (settle_q == '0) begin
                        samp_q  <= '0;
                        ones_q  <= '0;
                        state_q <= StSample;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                StSample: begin
                    if (abort) begin
                        {drv_in1, drv_in2, drv_in3} <= 3'b000;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else if (samp_q == SampLast) begin
                        shadow_q <= shadow_upd;
                        if (row_q == 3'd7) begin
                            {drv_in1, drv_in2, drv_in3} <= 3'b000;
                            done          <= 1'b1;
                            code          <= shadow_upd;
                            match         <= (shadow_upd == exp_q);
                            mismatch_mask <= shadow_upd ^ exp_q;
                            state_q       <= StDone;
                        end else begin
                            row_q    <= row_q + 3'd1;
                            {drv_in1, drv_in2, drv_in3} <= row_q + 3'd1;
                            settle_q <= SettleLoad;
                            state_q  <= StDrive;
                        end
                    end else begin
                        samp_q <= samp_q + 1'b1;
                        ones_q <= ones_sum;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/truth_table_extractor.md
Name: truth_table_extractor

Overview:
Sequential characterizer for 3-input combinational logic blocks, such as the 8-bit-coded truth-table modules in this codebase. It drives every input combination into an attached device under test, samples the DUT output, and assembles the 8-bit truth-table code. Row 000 maps to the MSB, so the same hex naming is used (e.g. 0xAC). The assembled code is optionally compared against an expected code. It sits in test/characterization harnesses alongside the gate library.

Parameters:
SETTLE_CYCLES, 4, cycles each row is driven before sampling; legal range >= 2, which covers the synchronizer latency
SAMPLES, 3, output samples per row for majority vote; odd, >= 1
CNT_W, 4, width of the settle/sample counters; must hold max(SETTLE_CYCLES, SAMPLES)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a sweep; accepted only in IDLE
abort  input  1  cancel the sweep in progress
expected  input  8  reference code; captured at start acceptance
dut_out  input  1  DUT output; asynchronous to clk
drv_in1  output  1  DUT input in1 (MSB of row index)
drv_in2  output  1  DUT input in2
drv_in3  output  1  DUT input in3 (LSB of row index)
busy  output  1  high from start acceptance through the DONE cycle
done  output  1  one-cycle pulse; code/match/mismatch_mask valid from this cycle
code  output  8  extracted truth table; bit (7-row) = DUT output for row {in1,in2,in3}
match  output  1  code == captured expected
mismatch_mask  output  8  code XOR captured expected

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; code=0x00, mismatch_mask=0x00, match=0; synchronizer flops and internal shadow register cleared.
- dut_out passes through a 2-flop synchronizer. Only the synchronized value is sampled.
- States:
  - IDLE: drv=000, busy=0. When start=1 at a clock edge: capture expected, clear shadow, row=0, load the settle counter, go to DRIVE.
  - DRIVE: drv={in1,in2,in3}=row. Stays SETTLE_CYCLES cycles, then goes to SAMPLE with the ones-counter cleared.
  - SAMPLE: drv unchanged. Stays SAMPLES cycles and counts synchronized ones.
    - On exit, shadow[7-row] = (ones > SAMPLES/2).
    - If row==7, go to DONE. Otherwise row++ and go to DRIVE.
  - DONE: one cycle. done=1, busy=1. code, match, mismatch_mask are registered from shadow in this cycle and held until the next DONE or reset. drv=000. Next state is IDLE.
- Timing: done is high in cycle 8*(SETTLE_CYCLES+SAMPLES)+1 after the start edge (57 with defaults). busy falls in the following cycle. A back-to-back start is accepted the cycle after DONE (first IDLE cycle).
- start while busy: ignored, no queuing.
- abort=1 in DRIVE or SAMPLE: next state IDLE, drv=000, no done pulse, code/match/mismatch_mask keep their previous values. Abort takes priority over any same-cycle state transition. abort in IDLE or DONE: no effect (DONE still completes).
- start and abort high together in IDLE: start is accepted, abort is ignored.
- Reset mid-sweep: immediate return to the reset values above.
- Row counter is 3 bits; the 7→0 wrap never occurs because the DONE transition is taken at row 7.

Test Plan:
- DUT modeled as 0xAC function (000→1,001→0,010→1,011→0,100→1,101→1,110→0,111→0), expected=0xAC, pulse start -> done at cycle 57, code=0xAC, match=1, mismatch_mask=0x00, busy high cycles 1..57.
- Same DUT, expected=0xAD -> code=0xAC, match=0, mismatch_mask=0x01. DUT = NOT in1 -> code=0xF0. DUT constant 0 -> code=0x00.
- 0xAC DUT with a one-cycle inverted glitch in row 2's SAMPLE window (SAMPLES=3) -> majority keeps code=0xAC.
- start pulsed again at cycle 20 of a sweep -> ignored; single done at 57. New start at cycle 58 -> second done at 58+57.
- abort during row 3 DRIVE after a prior sweep left code=0xAC -> busy=0 and drv=000 next cycle, no done, code stays 0xAC. Then a sweep with DUT=0x96 -> code=0x96.
- rst_n low mid-row 5 -> all outputs 0 and code=0x00 asynchronously. After release, start -> normal full sweep.
